// File: rtl/alarm_trigger.sv
// Alarm clock trigger: detects entry into the alarm minute, runs the
// IDLE/RINGING/SNOOZE sequence with tick-based timeouts and drives the
// buzzer beep pattern.
module alarm_trigger #(
  parameter int unsigned CLKS_PER_TICK = 50000,
  parameter int unsigned SNOOZE_TICKS  = 54000,
  parameter int unsigned RING_TICKS    = 60000,
  parameter int unsigned BEEP_TICKS    = 50
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset,
  input  logic        i_Alarm_Enable,
  input  logic [23:0] i_Current_Time_Stamp,
  input  logic [23:0] i_Alarm_Time_Stamp,
  input  logic        i_Snooze,
  input  logic        i_Stop,
  output logic        o_Ringing,
  output logic        o_Snoozing,
  output logic        o_Buzzer
);

  localparam int unsigned TS_W       = 24;
  localparam int unsigned CS_PER_MIN = 6000;
  localparam int unsigned TICK_MAX   = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int unsigned PRESC_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int unsigned TICK_W     = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned BEEP_W     = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLKS_PER_TICK - 1);
  localparam logic [TICK_W-1:0]  RING_LAST   = TICK_W'(RING_TICKS - 1);
  localparam logic [TICK_W-1:0]  SNOOZE_LAST = TICK_W'(SNOOZE_TICKS - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST   = BEEP_W'(BEEP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BEEP_W-1:0]   beep_q, beep_d;
  logic                phase_q, phase_d;
  logic                match_q;
  logic                ringing_q, snoozing_q, buzzer_q;
  logic                buzzer_d;

  logic [TS_W-1:0]     cur_min_c, alm_min_c;
  logic                match_c, trigger_c, tick_done_c, entry_c;

  // Minute-of-day comparison; seconds and hundredths are discarded.
  assign cur_min_c   = TS_W'(i_Current_Time_Stamp / TS_W'(CS_PER_MIN));
  assign alm_min_c   = TS_W'(i_Alarm_Time_Stamp / TS_W'(CS_PER_MIN));
  assign match_c     = (cur_min_c == alm_min_c);
  assign trigger_c   = match_c & ~match_q & i_Alarm_Enable;
  assign tick_done_c = (presc_q == PRESC_LAST);

  // Next-state selection with enable-low > stop > snooze > timeout priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger_c) state_d = ST_RINGING;
      end
      ST_RINGING: begin
        if (!i_Alarm_Enable)                    state_d = ST_IDLE;
        else if (i_Stop)                        state_d = ST_IDLE;
        else if (i_Snooze)                      state_d = ST_SNOOZE;
        else if (tick_done_c && tick_q == RING_LAST) state_d = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (!i_Alarm_Enable)                    state_d = ST_IDLE;
        else if (i_Stop)                        state_d = ST_IDLE;
        else if (tick_done_c && tick_q == SNOOZE_LAST) state_d = ST_RINGING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler, tick and beep-phase counters; all restart on every state entry.
  always_comb begin
    entry_c = (state_d != state_q);
    presc_d = presc_q;
    tick_d  = tick_q;
    beep_d  = beep_q;
    phase_d = phase_q;
    if (entry_c || state_d == ST_IDLE) begin
      presc_d = '0;
      tick_d  = '0;
      beep_d  = '0;
      phase_d = 1'b1;
    end else if (tick_done_c) begin
      presc_d = '0;
      tick_d  = tick_q + TICK_W'(1);
      if (beep_q == BEEP_LAST) begin
        beep_d  = '0;
        phase_d = ~phase_q;
      end else begin
        beep_d = beep_q + BEEP_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
    buzzer_d = (state_d == ST_RINGING) & phase_d;
  end

  // State, counters, match history and outputs all registered from next-state.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_q     <= '0;
      beep_q     <= '0;
      phase_q    <= 1'b1;
      match_q    <= 1'b1;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      beep_q     <= beep_d;
      phase_q    <= phase_d;
      match_q    <= match_c;
      ringing_q  <= (state_d == ST_RINGING);
      snoozing_q <= (state_d == ST_SNOOZE);
      buzzer_q   <= buzzer_d;
    end
  end

  assign o_Ringing  = ringing_q;
  assign o_Snoozing = snoozing_q;
  assign o_Buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger with a cycle-level reference model feeding a
// scoreboard, plus scenario tasks with direct timing checks.
module tb_alarm_trigger;

  localparam int unsigned CPT    = 4;
  localparam int unsigned SNZ    = 6;
  localparam int unsigned RNG    = 10;
  localparam int unsigned BP     = 2;
  localparam logic [23:0] ALM_TS = 24'd2700000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic [23:0] cur = '0;
  logic [23:0] alm = '0;
  logic        snz = 1'b0;
  logic        stop = 1'b0;
  logic        o_ring, o_snz, o_buz;

  typedef struct packed { logic r; logic s; logic b; } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int   m_state = 0;
  int   m_cnt = 0;
  logic m_prev = 1'b1;

  alarm_trigger #(
    .CLKS_PER_TICK(CPT), .SNOOZE_TICKS(SNZ), .RING_TICKS(RNG), .BEEP_TICKS(BP)
  ) dut (
    .i_Clk_5MHz(clk), .i_Reset(rst), .i_Alarm_Enable(en),
    .i_Current_Time_Stamp(cur), .i_Alarm_Time_Stamp(alm),
    .i_Snooze(snz), .i_Stop(stop),
    .o_Ringing(o_ring), .o_Snoozing(o_snz), .o_Buzzer(o_buz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Model one clock edge, push the expectation, advance, pop and compare.
  task automatic step();
    exp_t e;
    logic match, trig;
    int   nxt;
    match = ((cur / 6000) == (alm / 6000));
    trig  = match && !m_prev && en;
    nxt   = m_state;
    case (m_state)
      0: if (trig) nxt = 1;
      1: begin
        if (!en) nxt = 0;
        else if (stop) nxt = 0;
        else if (snz) nxt = 2;
        else if (m_cnt + 1 == int'(RNG * CPT)) nxt = 0;
      end
      2: begin
        if (!en) nxt = 0;
        else if (stop) nxt = 0;
        else if (m_cnt + 1 == int'(SNZ * CPT)) nxt = 1;
      end
      default: nxt = 0;
    endcase
    m_cnt   = (nxt != m_state) ? 0 : m_cnt + 1;
    m_state = nxt;
    m_prev  = match;
    e.r = (nxt == 1);
    e.s = (nxt == 2);
    e.b = (nxt == 1) && (((m_cnt / int'(BP * CPT)) % 2) == 0);
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    vectors++;
    if ({o_ring, o_snz, o_buz} !== {e.r, e.s, e.b}) begin
      miscompares++;
      $display("FAIL scoreboard t=%0t: got ring=%b snz=%b buz=%b, expected ring=%b snz=%b buz=%b",
               $time, o_ring, o_snz, o_buz, e.r, e.s, e.b);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_prev  = 1'b1;
  endtask

  // Leave the alarm minute, then jump straight into it.
  task automatic arm(input string tag);
    cur = 24'd100;
    step();
    cur = ALM_TS;
    step();
    vectors++;
    if (o_ring !== 1'b1 || o_buz !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_%s: ring=%b buz=%b, expected ring=1 buz=1", tag, o_ring, o_buz);
    end
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    snz = 1'b1; step(); snz = 1'b0;
  endtask

  task automatic test_reset();
    int rings;
    cur = '0; alm = '0; en = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({o_ring, o_snz, o_buz} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 000", {o_ring, o_snz, o_buz});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rings = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_ring) rings++;
    end
    vectors++;
    if (rings !== 0) begin
      miscompares++;
      $display("FAIL reset_equal_stamps: ringing cycles=%0d, expected 0", rings);
    end
  endtask

  task automatic test_rearm_after_reset();
    cur = 24'd6000;
    step();
    cur = 24'd0;
    step();
    vectors++;
    if (o_ring !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_ring: ring=%b, expected 1", o_ring);
    end
    pulse_stop();
    vectors++;
    if (o_ring !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_stop: ring=%b, expected 0", o_ring);
    end
  endtask

  task automatic test_ring_timeout();
    logic bz [0:63];
    int   n, rings;
    logic want;
    alm = ALM_TS; en = 1'b1;
    cur = 24'd2699999;
    steps(3);
    cur = ALM_TS;
    step();
    vectors++;
    if (o_ring !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_entry: ring=%b, expected 1", o_ring);
    end
    bz[0] = o_buz;
    n = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!o_ring) break;
      bz[n] = o_buz;
      n++;
    end
    vectors++;
    if (n !== 40) begin
      miscompares++;
      $display("FAIL timeout_length: ringing cycles=%0d, expected 40", n);
    end
    for (int i = 0; i < n && i < 40; i++) begin
      want = (((i / 8) % 2) == 0);
      vectors++;
      if (bz[i] !== want) begin
        miscompares++;
        $display("FAIL beep_pattern[%0d]: buz=%b, expected %b", i, bz[i], want);
      end
    end
    rings = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ring) rings++;
    end
    vectors++;
    if (rings !== 0) begin
      miscompares++;
      $display("FAIL timeout_no_retrigger: ringing cycles=%0d, expected 0", rings);
    end
  endtask

  task automatic test_snooze();
    int k, rings;
    cur = 24'd2699999;
    step();
    cur = ALM_TS;
    step();
    steps(3);
    pulse_snooze();
    vectors++;
    if ({o_ring, o_snz, o_buz} !== 3'b010) begin
      miscompares++;
      $display("FAIL snooze_entry: got ring/snz/buz=%b, expected 010", {o_ring, o_snz, o_buz});
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (o_ring) break;
    end
    vectors++;
    if (k !== 24) begin
      miscompares++;
      $display("FAIL snooze_length: cycles to re-ring=%0d, expected 24", k);
    end
    vectors++;
    if (o_buz !== 1'b1 || o_snz !== 1'b0) begin
      miscompares++;
      $display("FAIL snooze_rering_buzzer: buz=%b snz=%b, expected buz=1 snz=0", o_buz, o_snz);
    end
    steps(5);
    pulse_stop();
    vectors++;
    if (o_ring !== 1'b0 || o_snz !== 1'b0) begin
      miscompares++;
      $display("FAIL snooze_stop: ring=%b snz=%b, expected 0 0", o_ring, o_snz);
    end
    cur = 24'd2700500;
    rings = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_ring) rings++;
    end
    vectors++;
    if (rings !== 0) begin
      miscompares++;
      $display("FAIL stop_same_minute: ringing cycles=%0d, expected 0", rings);
    end
  endtask

  task automatic test_priority();
    arm("stop_snooze");
    steps(2);
    stop = 1'b1; snz = 1'b1;
    step();
    stop = 1'b0; snz = 1'b0;
    vectors++;
    if ({o_ring, o_snz} !== 2'b00) begin
      miscompares++;
      $display("FAIL prio_stop_over_snooze: ring/snz=%b, expected 00", {o_ring, o_snz});
    end
    arm("enable_snooze");
    en = 1'b0; snz = 1'b1;
    step();
    snz = 1'b0;
    vectors++;
    if ({o_ring, o_snz} !== 2'b00) begin
      miscompares++;
      $display("FAIL prio_enable_over_snooze: ring/snz=%b, expected 00", {o_ring, o_snz});
    end
    en = 1'b1;
    step();
    arm("retrigger_ignored");
    steps(2);
    cur = 24'd100;
    step();
    cur = ALM_TS;
    steps(3);
    pulse_snooze();
    steps(2);
    pulse_stop();
    vectors++;
    if ({o_ring, o_snz} !== 2'b00) begin
      miscompares++;
      $display("FAIL snooze_stop_prio: ring/snz=%b, expected 00", {o_ring, o_snz});
    end
    arm("snooze_disable");
    pulse_snooze();
    en = 1'b0;
    step();
    en = 1'b1;
    vectors++;
    if ({o_ring, o_snz} !== 2'b00) begin
      miscompares++;
      $display("FAIL snooze_disable: ring/snz=%b, expected 00", {o_ring, o_snz});
    end
    steps(3);
  endtask

  task automatic test_enable_mid_minute();
    int rings;
    en = 1'b0;
    cur = 24'd100;
    step();
    cur = ALM_TS;
    step();
    en = 1'b1;
    rings = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ring) rings++;
    end
    vectors++;
    if (rings !== 0) begin
      miscompares++;
      $display("FAIL enable_mid_minute: ringing cycles=%0d, expected 0", rings);
    end
  endtask

  task automatic test_async_reset();
    int buzz;
    arm("async_reset");
    pulse_snooze();
    steps(5);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({o_ring, o_snz, o_buz} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_snooze: got %b, expected 000", {o_ring, o_snz, o_buz});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    buzz = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_buz || o_ring) buzz++;
    end
    vectors++;
    if (buzz !== 0) begin
      miscompares++;
      $display("FAIL after_reset_quiet: active cycles=%0d, expected 0", buzz);
    end
    arm("ring_then_reset");
    steps(2);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({o_ring, o_snz, o_buz} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_ring: got %b, expected 000", {o_ring, o_snz, o_buz});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    steps(4);
  endtask

  initial begin
    test_reset();
    test_rearm_after_reset();
    test_ring_timeout();
    test_snooze();
    test_priority();
    test_enable_mid_minute();
    test_async_reset();
    vectors++;
    if (sb_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
